// File: rtl/latch_bank_pkg.sv
// Shared types for latch_bank: commit-scan FSM encoding and index-width helper.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/latch_bank_chan.sv
// One latch_bank channel: staging register, committed output register, pending flag.
// Optional registered even parity of the output register under LATCH_BANK_PARITY_EN.
module latch_bank_chan #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] SET_VAL = '1
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic             sset,
  input  logic             wr,
  input  logic             scan,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic             pending
`ifdef LATCH_BANK_PARITY_EN
  ,
  output logic             q_par
`endif
);

  logic [WIDTH-1:0] staging_q, staging_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             pend_q, pend_d;

  // A scan commits the value staged before this edge, so a same-cycle write
  // lands in staging and keeps pending set for the next scan.
  always_comb begin
    staging_d = staging_q;
    out_d     = out_q;
    pend_d    = pend_q;
    if (sset) begin
      staging_d = SET_VAL;
      out_d     = SET_VAL;
      pend_d    = 1'b0;
    end else begin
      if (scan && pend_q) begin
        out_d  = staging_q;
        pend_d = 1'b0;
      end
      if (wr) begin
        staging_d = wr_data;
        pend_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      staging_q <= '0;
      out_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      staging_q <= staging_d;
      out_q     <= out_d;
      pend_q    <= pend_d;
    end
  end

  assign q       = out_q;
  assign pending = pend_q;

`ifdef LATCH_BANK_PARITY_EN
  logic par_q, par_d;

  always_comb par_d = ^out_d;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) par_q <= 1'b0;
    else      par_q <= par_d;
  end

  assign q_par = par_q;
`endif

endmodule

// File: rtl/latch_bank.sv
// Bank of double-buffered channels committed by a one-channel-per-cycle scan.
// Optional per-channel output parity port q_par when LATCH_BANK_PARITY_EN is defined.
module latch_bank
  import latch_bank_pkg::*;
#(
  parameter int               WIDTH    = 4,
  parameter int               CHANNELS = 4,
  parameter logic [WIDTH-1:0] SET_VAL  = '1
) (
  input  logic                          clk,
  input  logic                          Aclr,
  input  logic                          Sset,
  input  logic                          wr_en,
  input  logic [idx_w(CHANNELS)-1:0]    wr_sel,
  input  logic [WIDTH-1:0]              wr_data,
  input  logic                          commit,
  output logic [CHANNELS*WIDTH-1:0]     q,
  output logic [CHANNELS-1:0]           pending,
  output logic                          busy,
  output logic                          commit_done
`ifdef LATCH_BANK_PARITY_EN
  ,
  output logic [CHANNELS-1:0]           q_par
`endif
);

  localparam int IW = idx_w(CHANNELS);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CHANNELS-1:0] wr_hit, scan_hit;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    if (Sset) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (commit) begin
            state_d = SCAN;
            idx_d   = '0;
          end
        end
        SCAN: begin
          if (idx_q == IW'(CHANNELS - 1)) state_d = DONE;
          else                            idx_d   = idx_q + 1'b1;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge Aclr) begin
    if (Aclr) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Out-of-range wr_sel matches no channel and is dropped.
  always_comb begin
    wr_hit   = '0;
    scan_hit = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      wr_hit[n]   = wr_en && (wr_sel == IW'(n));
      scan_hit[n] = (state_q == SCAN) && (idx_q == IW'(n));
    end
  end

  assign busy        = (state_q != IDLE);
  assign commit_done = (state_q == DONE);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_chan
    latch_bank_chan #(
      .WIDTH   (WIDTH),
      .SET_VAL (SET_VAL)
    ) u_chan (
      .clk     (clk),
      .aclr    (Aclr),
      .sset    (Sset),
      .wr      (wr_hit[n]),
      .scan    (scan_hit[n]),
      .wr_data (wr_data),
      .q       (q[n*WIDTH +: WIDTH]),
      .pending (pending[n])
`ifdef LATCH_BANK_PARITY_EN
      ,
      .q_par   (q_par[n])
`endif
    );
  end

endmodule

// File: tb/tb_latch_bank.sv
// Directed bench for latch_bank (WIDTH=4, CHANNELS=4) with a commit scoreboard.
// Parity checks are compiled in when LATCH_BANK_PARITY_EN is defined.
module tb_latch_bank;

  logic        clk = 1'b0;
  logic        Aclr;
  logic        Sset;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [3:0]  wr_data;
  logic        commit;
  logic [15:0] q;
  logic [3:0]  pending;
  logic        busy;
  logic        commit_done;
`ifdef LATCH_BANK_PARITY_EN
  logic [3:0]  q_par;
`endif

  typedef struct {
    logic [15:0] q;
    logic [3:0]  pend;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  latch_bank #(.WIDTH(4), .CHANNELS(4), .SET_VAL(4'hF)) dut (
    .clk         (clk),
    .Aclr        (Aclr),
    .Sset        (Sset),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_data     (wr_data),
    .commit      (commit),
    .q           (q),
    .pending     (pending),
    .busy        (busy),
    .commit_done (commit_done)
`ifdef LATCH_BANK_PARITY_EN
    ,
    .q_par       (q_par)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] sel, input logic [3:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_q"}, 32'(q), 32'(e.q));
      chk({tag, "_pending"}, 32'(pending), 32'(e.pend));
    end
  endtask

  // c0 = number of post-commit samples already taken; scan+done lasts 5 samples.
  task automatic finish_commit(input string tag, input int c0);
    int c = c0;
    while (commit_done !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    chk({tag, "_done_seen"}, 32'(commit_done), 32'd1);
    chk({tag, "_scan_len"}, 32'(c), 32'd5);
    chk({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    pop_check(tag);
    step();
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    chk({tag, "_idle_done"}, 32'(commit_done), 32'd0);
  endtask

  task automatic do_commit(input string tag, input logic [15:0] eq, input logic [3:0] ep);
    exp_t e;
    e.q = eq; e.pend = ep;
    sb.push_back(e);
    commit = 1'b1;
    step();
    commit = 1'b0;
    finish_commit(tag, 1);
  endtask

  initial begin
    exp_t e;
    Aclr = 1'b1; Sset = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_data = '0; commit = 1'b0;
    #2;
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(commit_done), 32'd0);
    step();
    Aclr = 1'b0;
    step();

    // Basic stage + commit.
    write(2'd2, 4'hA);
    write(2'd0, 4'h3);
    chk("stage_pending", 32'(pending), 32'h5);
    chk("stage_q_held", 32'(q), 32'd0);
    do_commit("basic", 16'h0A03, 4'h0);

    // Writes ahead of / behind the scan index, plus an ignored second commit.
    e.q = 16'h5A03; e.pend = 4'h1;
    sb.push_back(e);
    commit = 1'b1;
    step();
    commit = 1'b0;                 // idx0
    step();                        // idx1
    write(2'd3, 4'h5);             // now idx2
    write(2'd0, 4'h6);             // now idx3
    commit = 1'b1;
    step();
    commit = 1'b0;
    chk("mid_done", 32'(commit_done), 32'd1);
    pop_check("mid");
    step();
    chk("mid_idle_busy", 32'(busy), 32'd0);
    step();
    step();
    chk("no_queued_busy", 32'(busy), 32'd0);
    chk("no_queued_done", 32'(commit_done), 32'd0);
    do_commit("flush0", 16'h5A06, 4'h0);

    // Write and scan of the same channel in one cycle.
    write(2'd1, 4'h9);
    e.q = 16'h5A96; e.pend = 4'h2;
    sb.push_back(e);
    commit = 1'b1;
    step();
    commit = 1'b0;                 // idx0
    step();                        // idx1
    write(2'd1, 4'hC);             // serviced ch1 on this edge
    finish_commit("same", 3);
    do_commit("flush1", 16'h5AC6, 4'h0);

    // Sset beats write and commit.
    Sset = 1'b1; wr_en = 1'b1; wr_sel = 2'd1; wr_data = 4'h2; commit = 1'b1;
    step();
    Sset = 1'b0; wr_en = 1'b0; commit = 1'b0;
    chk("sset_q", 32'(q), 32'hFFFF);
    chk("sset_pending", 32'(pending), 32'd0);
    chk("sset_busy", 32'(busy), 32'd0);
    chk("sset_done", 32'(commit_done), 32'd0);
`ifdef LATCH_BANK_PARITY_EN
    chk("sset_par", 32'(q_par), 32'd0);
`endif
    do_commit("after_sset", 16'hFFFF, 4'h0);

    // Asynchronous clear mid-scan.
    write(2'd1, 4'h7);
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    Aclr = 1'b1;
    #1;
    chk("aclr_q", 32'(q), 32'd0);
    chk("aclr_pending", 32'(pending), 32'd0);
    chk("aclr_busy", 32'(busy), 32'd0);
    chk("aclr_done", 32'(commit_done), 32'd0);
    #1;
    Aclr = 1'b0;
    step();
    chk("post_aclr_busy", 32'(busy), 32'd0);
    do_commit("post_aclr", 16'h0000, 4'h0);

`ifdef LATCH_BANK_PARITY_EN
    write(2'd1, 4'h7);
    do_commit("par7", 16'h0070, 4'h0);
    chk("par_ch1_odd", 32'(q_par[1]), 32'd1);
    write(2'd1, 4'h3);
    do_commit("par3", 16'h0030, 4'h0);
    chk("par_ch1_even", 32'(q_par[1]), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
